// File: rtl/mru_pkg.sv
// Types shared by the button front end and the MRU stage.
package mru_pkg;

    typedef logic [2:0] btn_code_t;

    localparam btn_code_t CODE_NONE = 3'd0;
    localparam int        N_BTN_DEF = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_event_front_if.sv
// Press-event valid/ready channel between btn_event_front and the MRU stage.
interface btn_event_front_if;
    import mru_pkg::*;

    logic      press_valid;
    logic      press_ready;
    btn_code_t press_code;

    modport master (
        output press_valid,
        output press_code,
        input  press_ready
    );

    modport slave (
        input  press_valid,
        input  press_code,
        output press_ready
    );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, stability counter, qualified rise pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CW              = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic          s1;
    logic          s2;
    logic          armed;
    logic [1:0]    settle;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          flip;

    assign differ = s2 != level;
    assign flip   = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise   = flip && !level && armed;

    // A button must be seen released after reset before it may fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            level  <= 1'b0;
            armed  <= 1'b0;
            settle <= 2'b00;
            cnt    <= '0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            settle <= {settle[0], 1'b1};
            if (settle[1] && !s2 && !level)
                armed <= 1'b1;
            if (flip) begin
                level <= s2;
                cnt   <= '0;
            end else if (differ) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/btn_event_front.sv
// Raw buttons -> debounced levels and one-shot press events on a valid/ready channel.
// Define BTN_REPEAT_EN to add auto-repeat for the lowest-index held button.
module btn_event_front
    import mru_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_BTN-1:0]   b_raw,
    output logic [N_BTN-1:0]   btn_level,
    btn_event_front_if.master  press,
    output logic               overrun
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY,
                                    REPEAT_PERIOD) + 1);

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] inject;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] take;
    logic [N_BTN-1:0] set_v;
    logic             load;
    logic             found;
    btn_code_t        pick;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CW              (CW)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (b_raw[i]),
            .level (btn_level[i]),
            .rise  (rise[i])
        );
    end

`ifdef BTN_REPEAT_EN
    localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic [IW-1:0] li;
    logic          held;
    logic [IW-1:0] rep_idx;
    logic          rep_on;
    logic          rep_done;
    logic [CW-1:0] rep_cnt;
    logic [CW-1:0] rep_cnt_nxt;
    logic [CW-1:0] rep_goal;
    logic          rep_same;
    logic          rep_fire;

    always_comb begin
        held = |btn_level;
        li   = '0;
        for (int i = N_BTN - 1; i >= 0; i--)
            if (btn_level[i])
                li = IW'(i);
    end

    assign rep_same    = held && rep_on && (li == rep_idx);
    assign rep_cnt_nxt = rep_cnt + CW'(1);
    assign rep_goal    = rep_done ? CW'(REPEAT_PERIOD)
                                  : CW'(REPEAT_DELAY - 1);
    assign rep_fire    = rep_same && (rep_cnt_nxt == rep_goal);

    // rep_cnt holds the number of held cycles already seen for rep_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_idx  <= '0;
            rep_on   <= 1'b0;
            rep_done <= 1'b0;
            rep_cnt  <= '0;
        end else begin
            rep_idx <= li;
            rep_on  <= held;
            if (!rep_same) begin
                rep_cnt  <= held ? CW'(1) : '0;
                rep_done <= 1'b0;
            end else if (rep_fire) begin
                rep_cnt  <= '0;
                rep_done <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt_nxt;
            end
        end
    end

    always_comb begin
        inject = '0;
        if (rep_fire)
            inject[li] = 1'b1;
    end
`else
    assign inject = '0;
`endif

    always_comb begin
        take  = '0;
        pick  = CODE_NONE;
        found = 1'b0;
        load  = !press.press_valid || press.press_ready;
        for (int i = 0; i < N_BTN; i++) begin
            if (pending[i] && !found) begin
                found   = 1'b1;
                take[i] = 1'b1;
                pick    = btn_code_t'(i + 1);
            end
        end
        if (!load)
            take = '0;
    end

    assign set_v = rise | inject;

    // A pend landing on a bit that is not being drained this cycle is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending           <= '0;
            overrun           <= 1'b0;
            press.press_valid <= 1'b0;
            press.press_code  <= CODE_NONE;
        end else begin
            pending <= (pending & ~take) | set_v;
            if (|(set_v & pending & ~take))
                overrun <= 1'b1;
            if (load) begin
                press.press_valid <= found;
                press.press_code  <= pick;
            end
        end
    end

endmodule

// File: tb/tb_btn_event_front.sv
// Bench for btn_event_front: behavioural model, per-cycle compare, directed and random stimulus.
module tb_btn_event_front;
    import mru_pkg::*;

    localparam int N = 4;
    localparam int D = 4;
    localparam int R = 20;
    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] b_raw;
    logic [3:0] btn_level;
    logic       overrun;

    btn_event_front_if pif ();

    btn_event_front #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (R),
        .REPEAT_PERIOD   (P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .b_raw     (b_raw),
        .btn_level (btn_level),
        .press     (pif.master),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: level flips after D straight disagreeing sync samples,
    // presses queue as a bitmask, lowest index leaves first.
    bit         m_on = 1'b0;
    logic [3:0] p1, p2, m_lvl, m_arm, m_pend;
    int         streak [4];
    int         since_rst;
    bit         m_v;
    logic [2:0] m_code;
    bit         m_ov;
    int         prev_li;
    int         run;

    function automatic void model_step();
        logic [3:0] sy, lvl_old, rise, inj, take, setv;
        int li;
        if (rst) begin
            p1 = '0; p2 = '0; m_lvl = '0; m_arm = '0; m_pend = '0;
            for (int i = 0; i < 4; i++) streak[i] = 0;
            since_rst = 0; m_v = 0; m_code = '0; m_ov = 0;
            prev_li = -1; run = 0; m_on = 1'b1;
            return;
        end
        if (!m_on) return;
        sy = p2; lvl_old = m_lvl; rise = '0; inj = '0; take = '0;
        since_rst++;
        for (int i = 0; i < 4; i++) begin
            if (sy[i] != lvl_old[i]) streak[i]++;
            else streak[i] = 0;
            if (streak[i] == D) begin
                m_lvl[i] = sy[i];
                streak[i] = 0;
                if (sy[i] && m_arm[i]) rise[i] = 1'b1;
            end
            if (since_rst >= 3 && !sy[i] && !lvl_old[i]) m_arm[i] = 1'b1;
        end
        li = -1;
        for (int i = 3; i >= 0; i--) if (lvl_old[i]) li = i;
        if (li < 0) run = 0;
        else if (li == prev_li) run++;
        else run = 1;
        prev_li = li;
`ifdef BTN_REPEAT_EN
        if (li >= 0 && run >= R - 1 && ((run - (R - 1)) % P) == 0)
            inj[li] = 1'b1;
`endif
        if (!m_v || pif.press_ready) begin
            m_v = 0; m_code = '0;
            for (int i = 0; i < 4; i++)
                if (m_pend[i]) begin
                    m_v = 1; m_code = 3'(i + 1); take[i] = 1'b1; break;
                end
        end
        setv = rise | inj;
        if (|(setv & m_pend & ~take)) m_ov = 1;
        m_pend = (m_pend & ~take) | setv;
        p2 = p1; p1 = b_raw;
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            chk("m_level", 32'(btn_level), 32'(m_lvl));
            chk("m_valid", 32'(pif.press_valid), 32'(m_v));
            chk("m_code", 32'(pif.press_code), 32'(m_code));
            chk("m_overrun", 32'(overrun), 32'(m_ov));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic watch(input int n, output int nv);
        nv = 0;
        repeat (n) begin
            @(negedge clk);
            if (pif.press_valid) nv++;
        end
    endtask

    int nv;
    int hits[$];
    int want[$];

    initial begin
        rst = 1'b1; b_raw = 4'b0010; pif.press_ready = 1'b1;
        cyc(3);
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_valid", 32'(pif.press_valid), 0);
        chk("rst_code", 32'(pif.press_code), 0);
        chk("rst_ovr", 32'(overrun), 0);
        rst = 1'b0;
        watch(12, nv);
        chk("held_thru_rst_level", 32'(btn_level), 32'h2);
        chk("held_thru_rst_events", nv, 0);
        b_raw = 4'b0000; cyc(8);

        b_raw = 4'b0001; cyc(3); b_raw = 4'b0000;
        watch(10, nv);
        chk("glitch_level", 32'(btn_level), 0);
        chk("glitch_events", nv, 0);
        b_raw = 4'b0001; cyc(5);
        chk("deb_level_early", 32'(btn_level[0]), 0);
        cyc(1);
        chk("deb_level_on", 32'(btn_level[0]), 1);
        chk("deb_valid_pre", 32'(pif.press_valid), 0);
        cyc(1);
        chk("press1_valid", 32'(pif.press_valid), 1);
        chk("press1_code", 32'(pif.press_code), 1);
        cyc(1);
        chk("press1_once", 32'(pif.press_valid), 0);
        b_raw = 4'b0000; cyc(8);

        pif.press_ready = 1'b0; b_raw = 4'b1010; cyc(7);
        chk("multi_first", 32'(pif.press_code), 2);
        cyc(3);
        chk("multi_hold_v", 32'(pif.press_valid), 1);
        chk("multi_hold_c", 32'(pif.press_code), 2);
        pif.press_ready = 1'b1; cyc(1);
        chk("multi_second", 32'(pif.press_code), 4);
        cyc(1);
        chk("multi_drain", 32'(pif.press_valid), 0);
        b_raw = 4'b0000; cyc(8);

        pif.press_ready = 1'b0;
        b_raw = 4'b0100; cyc(7);
        chk("ovr_show3", 32'(pif.press_code), 3);
        b_raw = 4'b0000; cyc(7);
        b_raw = 4'b0100; cyc(7);
        b_raw = 4'b0000; cyc(7);
        chk("ovr_queued", 32'(overrun), 0);
        b_raw = 4'b0100; cyc(7);
        chk("ovr_set", 32'(overrun), 1);
        b_raw = 4'b0000; cyc(7);
        chk("ovr_sticky", 32'(overrun), 1);
        chk("ovr_still3", 32'(pif.press_code), 3);

        rst = 1'b1; cyc(1);
        chk("mid_rst_valid", 32'(pif.press_valid), 0);
        chk("mid_rst_code", 32'(pif.press_code), 0);
        chk("mid_rst_ovr", 32'(overrun), 0);
        rst = 1'b0; pif.press_ready = 1'b1;
        watch(20, nv);
        chk("post_rst_events", nv, 0);

        b_raw = 4'b0001;
        for (int k = 1; k <= 70; k++) begin
            cyc(1);
            if (pif.press_valid) hits.push_back(k);
            if (k == 50) b_raw = 4'b0000;
        end
`ifdef BTN_REPEAT_EN
        want = '{7, 26, 34, 42, 50};
`else
        want = '{7};
`endif
        chk("rep_count", hits.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            chk("rep_cycle", (i < hits.size()) ? hits[i] : -1, want[i]);
        cyc(8);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, (i == 0) ? 39 : 9) == 0)
                    b_raw[i] = ~b_raw[i];
            pif.press_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
